// File: rtl/hazard_controller_if.sv
// rtl/hazard_controller_if.sv - decode/EX hazard control bundle between pipeline and hazard controller
//
// Purpose: groups the decode-stage instruction fields, the EX branch result and
// the controller's forwarding/stall/flush responses into one bundle.
// Signals:
//   id_valid, id_opcode[6:0], id_rs1/id_rs2/id_rd[4:0] : decode-stage instruction
//   ex_branch_taken                                   : taken branch/JAL/JALR in EX
//   fwd_a, fwd_b[1:0]                                 : EX operand source (0 NONE, 1 EX_MEM, 2 MEM_WB)
//   stall_if_id, bubble_id_ex, flush_if_id, busy      : pipeline control
// Modports: master = pipeline side (drives decode info), slave = hazard controller.

interface hazard_controller_if;
  logic       id_valid;
  logic [6:0] id_opcode;
  logic [4:0] id_rs1;
  logic [4:0] id_rs2;
  logic [4:0] id_rd;
  logic       ex_branch_taken;
  logic [1:0] fwd_a;
  logic [1:0] fwd_b;
  logic       stall_if_id;
  logic       bubble_id_ex;
  logic       flush_if_id;
  logic       busy;

  modport master (
    output id_valid, id_opcode, id_rs1, id_rs2, id_rd, ex_branch_taken,
    input  fwd_a, fwd_b, stall_if_id, bubble_id_ex, flush_if_id, busy
  );

  modport slave (
    input  id_valid, id_opcode, id_rs1, id_rs2, id_rd, ex_branch_taken,
    output fwd_a, fwd_b, stall_if_id, bubble_id_ex, flush_if_id, busy
  );
endinterface

// File: rtl/hazard_controller.sv
// rtl/hazard_controller.sv - RAW hazard stall/forward and branch flush controller
//
// Purpose: tracks a shadow EX/MEM/WB pipeline of register usage, detects
// read-after-write hazards for the decode-stage instruction, and drives
// stall, bubble, flush and operand-forwarding controls.
// Ports:
//   clk   : core clock, all state updates on the rising edge
//   reset : synchronous active-high reset
//   hif   : hazard_controller_if.slave (decode info in, control out)
// Configuration macro: FORWARDING_EN
//   defined   : EX_MEM/MEM_WB forwarding; only a load in EX causes a 1-cycle stall
//   undefined : no forwarding; producer in EX stalls 2 cycles, in MEM 1 cycle

module hazard_controller (
  input  logic              clk,
  input  logic              reset,
  hazard_controller_if.slave hif
);

  localparam logic [6:0] OPC_LOAD    = 7'b0000011;
  localparam logic [6:0] OPC_OP_IMM  = 7'b0010011;
  localparam logic [6:0] OPC_U_AUIPC = 7'b0010111;
  localparam logic [6:0] OPC_STORE   = 7'b0100011;
  localparam logic [6:0] OPC_OP      = 7'b0110011;
  localparam logic [6:0] OPC_U_LUI   = 7'b0110111;
  localparam logic [6:0] OPC_BRANCH  = 7'b1100011;
  localparam logic [6:0] OPC_JALR    = 7'b1100111;
  localparam logic [6:0] OPC_J_JAL   = 7'b1101111;

  localparam logic [1:0] FWD_NONE   = 2'd0;
  localparam logic [1:0] FWD_EX_MEM = 2'd1;
  localparam logic [1:0] FWD_MEM_WB = 2'd2;

  typedef enum logic {RUN, STALL} state_e;

  typedef struct packed {
    logic       valid;
    logic [4:0] rd;
    logic       writes;
    logic       is_load;
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic       reads_rs1;
    logic       reads_rs2;
  } slot_t;

  state_e state_q, state_d;
  logic   cnt_q, cnt_d;
  slot_t  ex_q, mem_q, wb_q, ex_d;
  slot_t  id_slot;

  logic dec_r1, dec_r2, dec_w;
  logic haz_n1, haz_n2;
  logic stall, bubble, flush;
  logic [1:0] fwd_a, fwd_b;

  // Producer slot p writes a register the consumer slot c reads. Index 0 is
  // already excluded because reads/writes are cleared for x0 at decode.
  function automatic logic raw_match(input slot_t p, input slot_t c);
    return p.valid && p.writes && c.valid &&
           ((c.reads_rs1 && (p.rd == c.rs1)) || (c.reads_rs2 && (p.rd == c.rs2)));
  endfunction

  always_comb begin
    dec_r1 = 1'b0;
    dec_r2 = 1'b0;
    dec_w  = 1'b0;
    case (hif.id_opcode)
      OPC_OP:      begin dec_r1 = 1'b1; dec_r2 = 1'b1; dec_w = 1'b1; end
      OPC_OP_IMM:  begin dec_r1 = 1'b1; dec_w = 1'b1; end
      OPC_LOAD:    begin dec_r1 = 1'b1; dec_w = 1'b1; end
      OPC_STORE:   begin dec_r1 = 1'b1; dec_r2 = 1'b1; end
      OPC_BRANCH:  begin dec_r1 = 1'b1; dec_r2 = 1'b1; end
      OPC_JALR:    begin dec_r1 = 1'b1; dec_w = 1'b1; end
      OPC_J_JAL:   dec_w = 1'b1;
      OPC_U_LUI:   dec_w = 1'b1;
      OPC_U_AUIPC: dec_w = 1'b1;
      default: ;
    endcase
    id_slot           = '0;
    id_slot.valid     = hif.id_valid;
    id_slot.rd        = hif.id_rd;
    id_slot.rs1       = hif.id_rs1;
    id_slot.rs2       = hif.id_rs2;
    id_slot.is_load   = (hif.id_opcode == OPC_LOAD);
    id_slot.writes    = dec_w  && (hif.id_rd  != 5'd0);
    id_slot.reads_rs1 = dec_r1 && (hif.id_rs1 != 5'd0);
    id_slot.reads_rs2 = dec_r2 && (hif.id_rs2 != 5'd0);
  end

`ifdef FORWARDING_EN
  // Only a load still in EX cannot be forwarded in time: one bubble suffices.
  assign haz_n1 = raw_match(ex_q, id_slot) && ex_q.is_load;
  assign haz_n2 = 1'b0;

  function automatic logic [1:0] fwd_sel(input logic rd_en, input logic [4:0] rs);
    if (ex_q.valid && rd_en && mem_q.valid && mem_q.writes && (mem_q.rd == rs))
      return FWD_EX_MEM;
    else if (ex_q.valid && rd_en && wb_q.valid && wb_q.writes && (wb_q.rd == rs))
      return FWD_MEM_WB;
    else
      return FWD_NONE;
  endfunction

  assign fwd_a = fwd_sel(ex_q.reads_rs1, ex_q.rs1);
  assign fwd_b = fwd_sel(ex_q.reads_rs2, ex_q.rs2);
`else
  // Register file writes before it is read, so a WB producer is never a hazard.
  assign haz_n2 = raw_match(ex_q, id_slot);
  assign haz_n1 = !haz_n2 && raw_match(mem_q, id_slot);
  assign fwd_a  = FWD_NONE;
  assign fwd_b  = FWD_NONE;
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    stall   = 1'b0;
    bubble  = 1'b0;
    flush   = 1'b0;
    if (hif.ex_branch_taken) begin
      // Wrong-path instruction in ID is squashed, so any pending stall is moot.
      flush   = 1'b1;
      bubble  = 1'b1;
      state_d = RUN;
      cnt_d   = 1'b0;
    end else begin
      case (state_q)
        RUN: begin
          if (haz_n1 || haz_n2) begin
            stall  = 1'b1;
            bubble = 1'b1;
          end
          if (haz_n2) begin
            state_d = STALL;
            cnt_d   = 1'b1;
          end
        end
        STALL: begin
          // Counter holds the stall cycles remaining including this one.
          stall  = 1'b1;
          bubble = 1'b1;
          cnt_d  = cnt_q - 1'b1;
          if (cnt_d == 1'b0) state_d = RUN;
        end
        default: state_d = RUN;
      endcase
    end
  end

  always_comb begin
    ex_d = '0;
    if (hif.id_valid && !bubble) ex_d = id_slot;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= RUN;
      cnt_q   <= 1'b0;
      ex_q    <= '0;
      mem_q   <= '0;
      wb_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ex_q    <= ex_d;
      mem_q   <= ex_q;
      wb_q    <= mem_q;
    end
  end

  // Not every slot field feeds logic in every configuration.
  logic unused_slot_bits;
  assign unused_slot_bits = ^{ex_q, mem_q, wb_q};

  assign hif.fwd_a        = fwd_a;
  assign hif.fwd_b        = fwd_b;
  assign hif.stall_if_id  = stall;
  assign hif.bubble_id_ex = bubble;
  assign hif.flush_if_id  = flush;
  assign hif.busy         = (state_q == STALL);

endmodule

// File: doc/hazard_controller.md
HAZARD_CONTROLLER -- requirements
Module: hazard_controller

Interface
REQ-001 clk  in  1  core clock; all state updates on rising edge.
REQ-002 reset  in  1  synchronous, active-high reset.
REQ-003 id_valid  in  1  decode stage holds a valid instruction.
REQ-004 id_opcode  in  7  decode-stage opcode, instruction_format_type encoding.
REQ-005 id_rs1, id_rs2, id_rd  in  5 each  decode-stage register indices.
REQ-006 ex_branch_taken  in  1  branch/JAL/JALR in EX resolved taken this cycle.
REQ-007 fwd_a, fwd_b  out  2 each  EX operand source for rs1/rs2, forwarding_type (NONE, EX_MEM, MEM_WB).
REQ-008 stall_if_id  out  1  hold PC and IF/ID register.
REQ-009 bubble_id_ex  out  1  load NOP into ID/EX instead of the decoded instruction.
REQ-010 flush_if_id  out  1  squash IF/ID contents.
REQ-011 busy  out  1  high while in STALL state.

Function
REQ-012 Opcode decode: reads rs1 for OP, OP_IMM, LOAD, STORE, BRANCH, JALR; reads rs2 for OP, STORE, BRANCH; writes rd for OP, OP_IMM, LOAD, JALR, J_JAL, U_LUI, U_AUIPC; other opcodes read/write nothing.
REQ-013 Index 0 never reads or writes for hazard purposes.
REQ-014 Internal shadow pipeline of EX, MEM, WB slots, each {valid, rd, writes, is_load, rs1, rs2, reads_rs1, reads_rs2}; MEM<=EX and WB<=MEM every cycle.
REQ-015 EX slot <= ID info when id_valid=1 and bubble_id_ex=0; otherwise EX slot valid <= 0.
REQ-016 fwd_a = EX_MEM if MEM slot writes rd equal to EX rs1 (read, nonzero); else MEM_WB if WB slot matches; else NONE; fwd_b identical on rs2; combinational from slot registers.
REQ-017 FSM states RUN, STALL; 1-bit stall counter.
REQ-018 RAW hazard: valid ID instruction reads a nonzero register written by a valid producer slot.
REQ-019 In RUN, hazard of length N: stall_if_id=1, bubble_id_ex=1 this cycle; N=2 -> STALL with counter=1; N=1 -> stay RUN.
REQ-020 In STALL: stall_if_id=1, bubble_id_ex=1, busy=1, hazard detection suppressed; counter=0 -> RUN next cycle.
REQ-021 ex_branch_taken=1 (any state): flush_if_id=1, bubble_id_ex=1, stall_if_id=0, next state RUN, counter cleared; overrides stall.
REQ-022 flush_if_id asserted only in cycles where ex_branch_taken=1.
REQ-023 id_valid=0: no hazard, no stall.

Reset
REQ-024 reset=1: state RUN, counter 0, all slot valid bits 0, on the next edge.
REQ-025 Following reset: fwd_a=fwd_b=NONE, stall_if_id=0, bubble_id_ex=0, flush_if_id=0, busy=0.
REQ-026 reset asserted in STALL: STALL aborted, no residual stall cycle.

Configuration
REQ-027 Macro FORWARDING_EN defined: REQ-016 active; hazard only for LOAD in EX slot, N=1.
REQ-028 FORWARDING_EN undefined: fwd_a=fwd_b=NONE permanently; producer in EX -> N=2, producer in MEM (EX clear) -> N=1; WB producer never a hazard (register file write-before-read).

Verification
REQ-029 FORWARDING_EN: add x5 then add x6,x5,x1 back-to-back -> no stall; fwd_a=EX_MEM while second add in EX.
REQ-030 FORWARDING_EN: lw x7 then add x8,x7,x7 -> one cycle stall_if_id=bubble_id_ex=1; then fwd_a=fwd_b=MEM_WB.
REQ-031 FORWARDING_EN undefined: add x5 then sub x9,x5,x2 -> two stall cycles (busy=1 in second); fwd outputs NONE throughout.
REQ-032 Write to x0 followed by read of x0 -> no stall, fwd NONE, either configuration.
REQ-033 ex_branch_taken=1 during stall cycle 1 of a 2-cycle stall -> flush_if_id=1, stall_if_id=0, RUN next cycle, busy=0.
REQ-034 reset=1 while busy=1 -> next cycle all outputs 0/NONE; subsequent lw x3 / add x4,x3,x0 gives normal 1-cycle stall.
